// File: rtl/cpu_pipe_ctrl.sv
// Parametrised multicycle demo CPU: BOOT/FETCH/EXEC/HALTED control with a req/ready
// instruction fetch, GP register file and latched output channels exposed as flat buses.
module cpu_pipe_ctrl #(
   parameter  int DATA_W  = 8,
   parameter  int ADDR_W  = 8,
   parameter  int NREGS   = 4,
   parameter  int NIO     = 2,
   localparam int RIDX_W  = $clog2(NREGS),
   localparam int CH_W    = $clog2(NIO),
   localparam int INSTR_W = 3 + 3*RIDX_W + DATA_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [INSTR_W-1:0]      mem_value,
   input  logic                    mem_ready,
   input  logic [NIO*DATA_W-1:0]   inputs,
   output logic                    mem_req,
   output logic [ADDR_W-1:0]       mem_address,
   output logic [ADDR_W-1:0]       pc,
   output logic                    halt,
   output logic [NIO*DATA_W-1:0]   outputs,
   output logic [NREGS*DATA_W-1:0] regs
);

   typedef enum logic [1:0] {S_BOOT, S_FETCH, S_EXEC, S_HALTED} state_e;
   typedef enum logic [2:0] {
      OP_IN, OP_OUT, OP_ALU, OP_LI, OP_JMP, OP_JZ, OP_HALT, OP_NOP
   } op_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                req_q, req_d;
   logic                halt_q, halt_d;
   logic [INSTR_W-1:0]  ir_q, ir_d;
   logic [DATA_W-1:0]   regs_q [NREGS];
   logic [DATA_W-1:0]   regs_d [NREGS];
   logic [DATA_W-1:0]   outs_q [NIO];
   logic [DATA_W-1:0]   outs_d [NIO];
   logic [DATA_W-1:0]   in_ch  [NIO];

   op_e                 op;
   logic [RIDX_W-1:0]   rd, rs1, rs2;
   logic [DATA_W-1:0]   imm, rs1_val, rs2_val, alu_res;
   logic [ADDR_W-1:0]   pc_inc, next_pc;

   assign op      = op_e'(ir_q[2:0]);
   assign rd      = ir_q[3 +: RIDX_W];
   assign rs1     = ir_q[3 + RIDX_W +: RIDX_W];
   assign rs2     = ir_q[3 + 2*RIDX_W +: RIDX_W];
   assign imm     = ir_q[3 + 3*RIDX_W +: DATA_W];
   assign rs1_val = regs_q[rs1];
   assign rs2_val = regs_q[rs2];
   assign pc_inc  = pc_q + ADDR_W'(1);

   for (genvar c = 0; c < NIO; c++) begin : g_io
      assign in_ch[c]                    = inputs[c*DATA_W +: DATA_W];
      assign outputs[c*DATA_W +: DATA_W] = outs_q[c];
   end

   for (genvar r = 0; r < NREGS; r++) begin : g_regs
      assign regs[r*DATA_W +: DATA_W] = regs_q[r];
   end

   always_comb begin
      unique case (imm[1:0])
         2'd0:    alu_res = rs1_val + rs2_val;
         2'd1:    alu_res = rs1_val - rs2_val;
         2'd2:    alu_res = rs1_val & rs2_val;
         default: alu_res = rs1_val ^ rs2_val;
      endcase
   end

   always_comb begin
      next_pc = pc_inc;
      if (op == OP_JMP) begin
         next_pc = imm[ADDR_W-1:0];
      end else if (op == OP_JZ && rs1_val == '0) begin
         next_pc = imm[ADDR_W-1:0];
      end
   end

   // NOTE: every _d is given its hold value first, so no path through the case
   // below leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      req_d   = req_q;
      halt_d  = halt_q;
      ir_d    = ir_q;
      regs_d  = regs_q;
      outs_d  = outs_q;
      case (state_q)
         S_BOOT: begin
            req_d   = 1'b1;
            addr_d  = pc_q;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (mem_ready) begin
               ir_d    = mem_value;
               req_d   = 1'b0;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (op == OP_HALT) begin
               halt_d  = 1'b1;
               state_d = S_HALTED;
            end else begin
               pc_d    = next_pc;
               addr_d  = next_pc;
               req_d   = 1'b1;
               state_d = S_FETCH;
            end
            case (op)
               OP_IN:   regs_d[rd] = in_ch[imm[CH_W-1:0]];
               OP_OUT:  outs_d[imm[CH_W-1:0]] = rs1_val;
               OP_ALU:  regs_d[rd] = alu_res;
               OP_LI:   regs_d[rd] = imm;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values; the register file is reset too because it drives the
   // indicator stripes and must read all-zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_BOOT;
         pc_q    <= '0;
         addr_q  <= '0;
         req_q   <= 1'b0;
         halt_q  <= 1'b0;
         ir_q    <= '0;
         for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
         for (int c = 0; c < NIO; c++)   outs_q[c] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
         halt_q  <= halt_d;
         ir_q    <= ir_d;
         regs_q  <= regs_d;
         outs_q  <= outs_d;
      end
   end

   assign mem_req     = req_q;
   assign mem_address = addr_q;
   assign pc          = pc_q;
   assign halt        = halt_q;

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// Bench for cpu_pipe_ctrl: a program memory model answers fetches, a queue holds the
// expected fetch-address sequence of each program, and per-scenario tasks check end state.
module tb_cpu_pipe_ctrl;

   localparam int DATA_W  = 8;
   localparam int ADDR_W  = 8;
   localparam int NREGS   = 4;
   localparam int NIO     = 2;
   localparam int RIDX_W  = $clog2(NREGS);
   localparam int INSTR_W = 3 + 3*RIDX_W + DATA_W;

   logic                    clk;
   logic                    rst_n;
   logic [INSTR_W-1:0]      mem_value;
   logic                    mem_ready;
   logic [NIO*DATA_W-1:0]   inputs;
   logic                    mem_req;
   logic [ADDR_W-1:0]       mem_address;
   logic [ADDR_W-1:0]       pc;
   logic                    halt;
   logic [NIO*DATA_W-1:0]   outputs;
   logic [NREGS*DATA_W-1:0] regs;

   logic [INSTR_W-1:0] prog [256];
   logic [ADDR_W-1:0]  exp_addr [$];
   int vectors     = 0;
   int miscompares = 0;

   cpu_pipe_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .NIO(NIO)) dut (
      .clk(clk), .rst_n(rst_n), .mem_value(mem_value), .mem_ready(mem_ready),
      .inputs(inputs), .mem_req(mem_req), .mem_address(mem_address), .pc(pc),
      .halt(halt), .outputs(outputs), .regs(regs)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [INSTR_W-1:0] enc(input int op, input int rd, input int rs1,
                                              input int rs2, input int imm);
      return {imm[DATA_W-1:0], rs2[RIDX_W-1:0], rs1[RIDX_W-1:0], rd[RIDX_W-1:0], op[2:0]};
   endfunction

   function automatic logic [DATA_W-1:0] reg_at(input int r);
      return regs[r*DATA_W +: DATA_W];
   endfunction

   task automatic clear_prog();
      for (int a = 0; a < 256; a++) prog[a] = enc(7, 0, 0, 0, 0);
      exp_addr.delete();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Memory model: answers each request after lat idle cycles; checks the held
   // request during stalls and the fetch address against the expected queue.
   task automatic run(input int lat, input int budget, input bit complete);
      int cyc = 0;
      int wait_n = 0;
      logic [ADDR_W-1:0] held = '0;
      logic [ADDR_W-1:0] e;
      while (exp_addr.size() > 0) begin
         @(negedge clk);
         cyc++;
         mem_ready = 1'b0;
         if (cyc > budget) begin
            vectors++; miscompares++;
            $display("FAIL run_budget: %0d fetches still expected after %0d cycles", exp_addr.size(), budget);
            exp_addr.delete();
            break;
         end
         if (mem_req) begin
            if (wait_n == 0) begin
               held = mem_address;
            end else begin
               vectors++;
               if (mem_address !== held || pc !== held) begin
                  miscompares++;
                  $display("FAIL stall_hold: addr %h pc %h, required %h", mem_address, pc, held);
               end
            end
            if (wait_n < lat) begin
               wait_n++;
            end else begin
               e = exp_addr.pop_front();
               vectors++;
               if (mem_address !== e) begin
                  miscompares++;
                  $display("FAIL fetch_addr: got %h, required %h", mem_address, e);
               end
               mem_value = prog[mem_address];
               mem_ready = 1'b1;
               wait_n    = 0;
            end
         end
      end
      if (complete) begin
         @(negedge clk);
         mem_ready = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++; if (pc !== '0) begin miscompares++; $display("FAIL reset_pc: got %h, required 0", pc); end
      vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b, required 0", mem_req); end
      vectors++; if (mem_address !== '0) begin miscompares++; $display("FAIL reset_addr: got %h, required 0", mem_address); end
      vectors++; if (halt !== 1'b0) begin miscompares++; $display("FAIL reset_halt: got %b, required 0", halt); end
      vectors++; if (regs !== '0) begin miscompares++; $display("FAIL reset_regs: got %h, required 0", regs); end
      vectors++; if (outputs !== '0) begin miscompares++; $display("FAIL reset_outputs: got %h, required 0", outputs); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++; if (mem_req !== 1'b1 || mem_address !== '0) begin miscompares++; $display("FAIL boot_fetch: req %b addr %h, required 1 00", mem_req, mem_address); end
   endtask

   task automatic test_sub_halt();
      clear_prog();
      prog[0] = enc(3, 1, 0, 0, 5);
      prog[1] = enc(3, 2, 0, 0, 3);
      prog[2] = enc(2, 3, 1, 2, 1);
      prog[3] = enc(6, 0, 0, 0, 0);
      exp_addr = '{8'h00, 8'h01, 8'h02, 8'h03};
      apply_reset();
      run(0, 200, 1'b1);
      vectors++; if (reg_at(3) !== 8'h02) begin miscompares++; $display("FAIL sub_r3: got %h, required 02", reg_at(3)); end
      vectors++; if (halt !== 1'b1) begin miscompares++; $display("FAIL sub_halt: got %b, required 1", halt); end
      vectors++; if (pc !== 8'h03) begin miscompares++; $display("FAIL sub_pc: got %h, required 03", pc); end
      mem_ready = 1'b1;
      repeat (4) @(negedge clk);
      mem_ready = 1'b0;
      vectors++; if (mem_req !== 1'b0 || pc !== 8'h03 || halt !== 1'b1) begin miscompares++; $display("FAIL halted_hold: req %b pc %h halt %b, required 0 03 1", mem_req, pc, halt); end
      vectors++; if (outputs !== '0) begin miscompares++; $display("FAIL sub_outputs: got %h, required 0", outputs); end
   endtask

   task automatic test_alu();
      clear_prog();
      prog[0] = enc(3, 1, 0, 0, 'hF0);
      prog[1] = enc(3, 2, 0, 0, 'h20);
      prog[2] = enc(2, 0, 1, 2, 0);
      prog[3] = enc(2, 3, 1, 2, 2);
      prog[4] = enc(2, 1, 1, 2, 3);
      prog[5] = enc(6, 0, 0, 0, 0);
      exp_addr = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      apply_reset();
      run(1, 300, 1'b1);
      vectors++; if (reg_at(0) !== 8'h10) begin miscompares++; $display("FAIL alu_add: got %h, required 10", reg_at(0)); end
      vectors++; if (reg_at(3) !== 8'h20) begin miscompares++; $display("FAIL alu_and: got %h, required 20", reg_at(3)); end
      vectors++; if (reg_at(1) !== 8'hD0) begin miscompares++; $display("FAIL alu_xor_rd_eq_rs1: got %h, required d0", reg_at(1)); end
      vectors++; if (reg_at(2) !== 8'h20) begin miscompares++; $display("FAIL alu_r2: got %h, required 20", reg_at(2)); end
   endtask

   task automatic test_io();
      clear_prog();
      inputs  = {8'hA5, 8'h3C};
      prog[0] = enc(0, 2, 0, 0, 1);
      prog[1] = enc(1, 0, 2, 0, 0);
      prog[2] = enc(6, 0, 0, 0, 0);
      exp_addr = '{8'h00, 8'h01, 8'h02};
      apply_reset();
      run(0, 200, 1'b1);
      vectors++; if (reg_at(2) !== 8'hA5) begin miscompares++; $display("FAIL io_in: got %h, required a5", reg_at(2)); end
      vectors++; if (outputs !== 16'h00A5) begin miscompares++; $display("FAIL io_out: got %h, required 00a5", outputs); end
   endtask

   task automatic test_stall_jz();
      clear_prog();
      prog[8'h00] = enc(5, 0, 0, 0, 'h40);
      prog[8'h40] = enc(3, 0, 0, 0, 1);
      prog[8'h41] = enc(5, 0, 0, 0, 'h10);
      prog[8'h42] = enc(6, 0, 0, 0, 0);
      exp_addr = '{8'h00, 8'h40, 8'h41, 8'h42};
      apply_reset();
      run(5, 300, 1'b1);
      vectors++; if (pc !== 8'h42 || halt !== 1'b1) begin miscompares++; $display("FAIL jz_end: pc %h halt %b, required 42 1", pc, halt); end
      vectors++; if (regs !== 32'h0000_0001) begin miscompares++; $display("FAIL jz_regs: got %h, required 00000001", regs); end
   endtask

   task automatic test_wrap();
      clear_prog();
      prog[8'h00] = enc(4, 0, 0, 0, 'hFF);
      prog[8'hFF] = enc(7, 0, 0, 0, 0);
      exp_addr = '{8'h00, 8'hFF, 8'h00};
      apply_reset();
      run(0, 200, 1'b1);
      vectors++; if (mem_req !== 1'b1 || mem_address !== 8'hFF || pc !== 8'hFF) begin miscompares++; $display("FAIL wrap_refetch: req %b addr %h pc %h, required 1 ff ff", mem_req, mem_address, pc); end
   endtask

   task automatic test_reset_mid_exec();
      clear_prog();
      prog[0] = enc(3, 2, 0, 0, 7);
      prog[1] = enc(3, 1, 0, 0, 9);
      exp_addr = '{8'h00, 8'h01};
      apply_reset();
      run(0, 200, 1'b0);
      @(negedge clk);
      mem_ready = 1'b0;
      vectors++; if (reg_at(2) !== 8'h07 || pc !== 8'h01 || mem_req !== 1'b0) begin miscompares++; $display("FAIL pre_reset_exec: r2 %h pc %h req %b, required 07 01 0", reg_at(2), pc, mem_req); end
      rst_n = 1'b0;
      #1;
      vectors++; if (regs !== '0 || pc !== '0 || mem_req !== 1'b0 || mem_address !== '0) begin miscompares++; $display("FAIL mid_exec_reset: regs %h pc %h req %b addr %h, required all 0", regs, pc, mem_req, mem_address); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++; if (mem_req !== 1'b1 || mem_address !== '0 || reg_at(1) !== '0) begin miscompares++; $display("FAIL post_reset_fetch: req %b addr %h r1 %h, required 1 00 00", mem_req, mem_address, reg_at(1)); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      mem_value = '0;
      inputs    = '0;
      test_reset();
      test_sub_halt();
      test_alu();
      test_io();
      test_stall_jz();
      test_wrap();
      test_reset_mid_exec();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
